pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline-stage register: the generalised replacement for the fixed-width IF/ID latch, usable between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a DATA_W-bit payload under a valid/ready handshake. It keeps the existing flush (clear to bubble) and freeze (hold) controls. An optional skid slot gives full throughput with a registered upstream ready.

## Interface
- DATA_W, 64, payload width; 64 covers a {pc[31:0], instruction[31:0]} IF/ID payload.
- CLR_VAL, '0, payload value loaded on reset and on flush.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage accepts payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a live payload.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  DATA_W  registered payload.
- flush  in  1  discard all held payloads; stage becomes an empty bubble.
- freeze  in  1  hold all state; no transfers in either direction.

## Operation
- Accept: `in_valid && in_ready`. Consume: `out_valid && out_ready && !freeze && !flush`.
- Priority, highest first:
  1. rst
  2. flush
  3. freeze
  4. normal handshake
- rst or flush:
  - out_valid ← 0, out_data ← CLR_VAL.
  - The skid slot is emptied.
  - in_ready is 0 that cycle, so no payload is accepted or lost silently.
- freeze (without flush):
  - All registers hold.
  - in_ready = 0.
  - out_valid and out_data stay visible but out_ready is ignored.
- Skid mode has three states:
  - EMPTY: main slot invalid, skid slot invalid.
  - ONE: main slot valid, skid slot invalid.
  - FULL: both slots valid.
- Transitions (normal handshake):
  - EMPTY + accept → ONE. in_data goes to the main slot.
  - ONE + accept + consume → ONE. Main slot ← in_data.
  - ONE + accept, no consume → FULL. in_data goes to the skid slot.
  - ONE + consume, no accept → EMPTY.
  - FULL + consume → ONE. Main slot ← skid slot, preserving FIFO order.
  - FULL, no consume → FULL.
- in_ready = !skid_valid && !freeze && !flush && !rst. It depends on no downstream combinational input.
- out_data retains its last value when out_valid drops through consumption. It is overwritten with CLR_VAL only by rst or flush.

## Timing
- Latency: a payload accepted at edge N appears on out_data/out_valid after edge N, i.e. 1 cycle.
- Throughput: 1 payload/cycle sustained while out_ready = 1.
- During and after rst:
  - out_valid = 0, out_data = CLR_VAL.
  - in_ready = 0 while rst is high and 1 from the first cycle after.
- Flush asserted in cycle N:
  - Bubble from edge N.
  - An in_valid presented in cycle N is not accepted.
  - An accept in cycle N+1 is legal.
- Freeze and out_ready both high: no consume occurs, and downstream must not treat it as one.
- Flush and freeze both high: flush wins.
- rst mid-transfer, including the FULL state: all payloads are dropped and the stage goes to EMPTY.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - Two-slot behaviour as above.
  - in_ready is registered-only (plus freeze/flush/rst gating).
- PIPE_STAGE_SKID_EN undefined:
  - Single slot; the FULL state does not exist.
  - in_ready = (!out_valid || out_ready) && !freeze && !flush && !rst, which is a combinational path from out_ready.
  - Latency, throughput, flush and freeze semantics are identical.

## Structure
- Shared package pipe_pkg holds:
  - the slot-state enum {EMPTY, ONE, FULL};
  - constants IF_ID_W = 64, PC_W = 32 and INSTR_W = 32, plus the other stage payload widths as added.
- One natural sub-module: pipe_skid_buf, the skid slot (data register + valid bit + load/clear).
  - It is instantiated only under PIPE_STAGE_SKID_EN.

## Test plan
- Reset: hold rst 3 cycles with in_valid = 1, in_data = 64'hAAAA_0000_1234_5678 → out_valid = 0, out_data = 0, in_ready = 0. in_ready = 1 in the first cycle after rst drops.
- Streaming: with out_ready = 1, send payloads 1..8 on consecutive cycles → out_data = 1..8 on the following 8 cycles, no gaps, in_ready never drops.
- Back-pressure (skid): send 0x10 and 0x11 back to back with out_ready = 0 → state FULL and in_ready = 0. Then raise out_ready → 0x10 is consumed, then 0x11, and in_ready returns to 1 one cycle after the FULL→ONE edge.
- Flush: in FULL holding 0x20 and 0x21, assert flush for 1 cycle with in_valid = 1, in_data = 0x22 → out_valid = 0, out_data = CLR_VAL, and 0x22 is not accepted. 0x23 sent the next cycle appears alone.
- Freeze: with 0x30 held, assert freeze for 4 cycles with out_ready = 1 and in_valid = 1 → out_data stays 0x30, out_valid stays 1, in_ready = 0, and nothing is consumed. Release → 0x30 is consumed exactly once.
- Flush + freeze together while 0x40 is held → flush wins: out_valid = 0, out_data = CLR_VAL. Repeat every scenario with PIPE_STAGE_SKID_EN undefined and check identical output sequences.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: slot-state encoding and stage payload widths.
// Used by pipe_stage_reg and pipe_skid_buf.
package pipe_pkg;

  // Occupancy of a stage register. FULL only exists when the skid slot is built.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } slot_state_t;

  // IF/ID payload is {pc, instruction}.
  localparam int PC_W     = 32;
  localparam int INSTR_W  = 32;
  localparam int IF_ID_W  = PC_W + INSTR_W;

  // Register-file word and the later stage payloads built from it.
  localparam int REG_W    = 32;
  localparam int RIDX_W   = 5;
  // pc, rs1 value, rs2 value, immediate, rd index, 16 bits of decoded control
  localparam int ID_EX_W  = PC_W + 3*REG_W + RIDX_W + 16;
  // alu result, store data, rd index, 8 bits of control
  localparam int EX_MEM_W = 2*REG_W + RIDX_W + 8;
  // writeback value, rd index, write-enable
  localparam int MEM_WB_W = REG_W + RIDX_W + 1;

  // A stage presents a live payload in every state except EMPTY.
  function automatic logic slot_live(slot_state_t s);
    return s != EMPTY;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid slot of an elastic stage register: one data word plus its valid bit.
// Only instantiated when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_buf #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,   // capture d, slot becomes valid
  input  logic              clr,    // drain or discard the slot
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  // Clear wins over load: a flush never leaves a stale payload parked here.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid <= 1'b0;
      q     <= CLR_VAL;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register with flush (bubble) and freeze (hold).
// Define PIPE_STAGE_SKID_EN for the two-slot version with a registered in_ready;
// without it the stage is a single slot whose in_ready passes out_ready through.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = IF_ID_W,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              freeze
);

  slot_state_t state;
  logic        accept;
  logic        consume;

  // A consume needs a live payload and a stage that is neither frozen nor flushed;
  // out_ready alone under freeze is not a transfer.
  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready && !freeze && !flush;

`ifdef PIPE_STAGE_SKID_EN
  logic              sk_valid;
  logic [DATA_W-1:0] sk_data;
  logic              sk_load;
  logic              sk_clr;

  // An accept into an occupied main slot that is not draining parks in the skid slot;
  // the skid slot empties when it refills the main slot or on flush.
  assign sk_load = (state == ONE) && accept && !consume;
  assign sk_clr  = flush || ((state == FULL) && consume);

  pipe_skid_buf #(
    .DATA_W  (DATA_W),
    .CLR_VAL (CLR_VAL)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (sk_load),
    .clr   (sk_clr),
    .d     (in_data),
    .valid (sk_valid),
    .q     (sk_data)
  );

  // Ready comes from state only, so no path from out_ready reaches upstream.
  assign in_ready = !sk_valid && !freeze && !flush && !rst;
`else
  // Single slot: room exists when empty or when the held payload leaves this cycle.
  assign in_ready = (!out_valid || out_ready) && !freeze && !flush && !rst;
`endif

  // Slot FSM: reset/flush bubble, freeze hold, otherwise follow the handshake.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= CLR_VAL;
    end else if (!freeze) begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            out_valid <= 1'b1;
            out_data  <= in_data;
          end
        end
        ONE: begin
          if (accept && consume) begin
            out_data <= in_data;
`ifdef PIPE_STAGE_SKID_EN
          end else if (accept) begin
            state <= FULL;
`endif
          end else if (consume) begin
            // out_data keeps its last value; only rst/flush reload CLR_VAL
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL: begin
          if (consume) begin
            state    <= ONE;
            out_data <= sk_data;
          end
        end
`endif
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios then random traffic,
// compared every cycle against a queue model of the stage.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        flush;
  logic        freeze;

  int npass = 0;
  int ntotal = 0;

  // Model: FIFO of held payloads plus the last value shown on out_data.
  logic [63:0] q[$];
  logic [63:0] hold;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .CLR_VAL('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .freeze    (freeze)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic model_ready();
    if (rst || flush || freeze) return 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  task automatic model_edge();
    logic a, c;
    if (rst || flush) begin
      q.delete();
      hold = '0;
    end else if (!freeze) begin
      a = in_valid && model_ready();
      c = (q.size() > 0) && out_ready;
      if (c) void'(q.pop_front());
      if (a) q.push_back(in_data);
      if (q.size() > 0) hold = q[0];
    end
  endtask

  // Inputs are set at the falling edge; check mid-low-phase, then take one rising edge.
  task automatic cycle();
    #2;
    chk("in_ready", {63'd0, in_ready}, {63'd0, model_ready()});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    chk("out_data", out_data, hold);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; in_data = '0; out_ready = 0; flush = 0; freeze = 0;
  endtask

  initial begin
    rst = 1; idle();
    in_valid = 1; in_data = 64'hAAAA_0000_1234_5678;
    @(posedge clk); model_edge(); @(negedge clk);
    // reset held with an upstream payload offered
    for (int i = 0; i < 2; i++) cycle();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 0; in_valid = 0;
    #1 chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    cycle();

    // streaming 1..8 with out_ready high
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1; in_data = 64'(k);
      cycle();
      chk("stream_data", out_data, 64'(k));
      chk("stream_ready", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 0;
    cycle();

    // back-pressure: 0x10, 0x11 back to back while stalled
    out_ready = 0;
    in_valid = 1; in_data = 64'h10; cycle();
    in_data = 64'h11; cycle();
    in_valid = 0;
`ifdef PIPE_STAGE_SKID_EN
    #1 chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
`endif
    cycle();
    out_ready = 1;
    for (int i = 0; i < 4; i++) cycle();
    out_ready = 0;

    // flush while holding 0x20/0x21, with 0x22 offered
    in_valid = 1; in_data = 64'h20; cycle();
    in_data = 64'h21; cycle();
    flush = 1; in_data = 64'h22; cycle();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_data", out_data, 64'd0);
    flush = 0; in_data = 64'h23; cycle();
    in_valid = 0; cycle();
    chk("after_flush_data", out_data, 64'h23);
    out_ready = 1; cycle(); cycle();

    // freeze 4 cycles with 0x30 held and both sides asking
    out_ready = 0; in_valid = 1; in_data = 64'h30; cycle();
    freeze = 1; out_ready = 1; in_data = 64'h31;
    for (int i = 0; i < 4; i++) cycle();
    chk("freeze_data", out_data, 64'h30);
    chk("freeze_valid", {63'd0, out_valid}, 64'd1);
    freeze = 0; in_valid = 0; cycle();
    chk("freeze_release_valid", {63'd0, out_valid}, 64'd0);
    cycle();

    // flush and freeze together while 0x40 held
    out_ready = 0; in_valid = 1; in_data = 64'h40; cycle();
    in_valid = 0; flush = 1; freeze = 1; cycle();
    chk("flush_freeze_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_freeze_data", out_data, 64'd0);
    idle(); cycle();

    // random traffic including occasional rst/flush/freeze
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      freeze    = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 0; idle(); cycle();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
